// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding multi-byte words to a byte-wide UART transmitter.
// Optional header byte (8'hA0 | id) per transfer when UART_TX_ARB_HEADER_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4,
  parameter int IDW    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*NBYTES*8-1:0] i_data,
  output logic [NREQ-1:0]          o_ack,
  output logic [IDW-1:0]           o_grant_id,
  output logic                     o_busy,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_din,
  input  logic                     i_tx_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam int WW = NBYTES * 8;
`ifdef UART_TX_ARB_HEADER_EN
  localparam int NSEND = NBYTES + 1;
`else
  localparam int NSEND = NBYTES;
`endif
  localparam logic [3:0] LAST = 4'(NSEND - 1);

  // Byte k of the outgoing sequence; header (if any) occupies slot 0.
  function automatic logic [7:0] pick(
    input logic [3:0]     k,
    input logic [WW-1:0]  b,
    input logic [IDW-1:0] id
  );
    logic [7:0] r;
    r = 8'h00;
`ifdef UART_TX_ARB_HEADER_EN
    if (k == 4'd0) r = 8'hA0 | 8'(id);
    for (int j = 0; j < NBYTES; j++)
      if (k == 4'(j + 1)) r = b[j*8 +: 8];
`else
    for (int j = 0; j < NBYTES; j++)
      if (k == 4'(j)) r = b[j*8 +: 8];
`endif
    return r;
  endfunction

  // {found, id}: scan from last+1 so the lowest offset wins.
  function automatic logic [IDW:0] rr_pick(
    input logic [IDW-1:0]  last,
    input logic [NREQ-1:0] e
  );
    logic [IDW:0] r;
    int           id;
    r = {1'b0, last};
    for (int i = NREQ; i >= 1; i--) begin
      id = (int'(last) + i) % NREQ;
      if (e[id]) r = {1'b1, IDW'(id)};
    end
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [WW-1:0]   buf_q, buf_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      din_q, din_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [IDW:0]    arb;
  logic [IDW-1:0]  win;
  logic [WW-1:0]   word;
  logic [3:0]      idx_inc;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    din_d   = din_q;
    ack_d   = '0;
    // The requester acked this cycle sits out one arbitration round.
    arb     = rr_pick(grant_q, i_req & ~ack_q);
    win     = arb[IDW-1:0];
    word    = i_data[win*WW +: WW];
    idx_inc = idx_q + 4'd1;
    unique case (state_q)
      S_IDLE: begin
        if (arb[IDW]) begin
          state_d = S_START;
          grant_d = win;
          buf_d   = word;
          idx_d   = 4'd0;
          din_d   = pick(4'd0, word, win);
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST) begin
            state_d         = S_IDLE;
            ack_d[grant_q]  = 1'b1;
          end else begin
            state_d = S_START;
            idx_d   = idx_inc;
            din_d   = pick(idx_inc, buf_q, grant_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      grant_q <= IDW'(NREQ - 1);
      buf_q   <= '0;
      idx_q   <= 4'd0;
      din_q   <= 8'h00;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_grant_id = grant_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_tx_start = (state_q == S_START);
  assign o_tx_din   = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level model.
// Honours UART_TX_ARB_HEADER_EN the same way the design does.
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int NBYTES = 4;
  localparam int IDW    = 2;
  localparam int DW     = NREQ * NBYTES * 8;
`ifdef UART_TX_ARB_HEADER_EN
  localparam int NSEND = NBYTES + 1;
`else
  localparam int NSEND = NBYTES;
`endif

  logic            i_clk;
  logic            i_reset;
  logic [NREQ-1:0] i_req;
  logic [DW-1:0]   i_data;
  logic [NREQ-1:0] o_ack;
  logic [IDW-1:0]  o_grant_id;
  logic            o_busy;
  logic            o_tx_start;
  logic [7:0]      o_tx_din;
  logic            i_tx_done;

  uart_tx_arbiter #(.NREQ(NREQ), .NBYTES(NBYTES), .IDW(IDW)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_tx_start (o_tx_start),
    .o_tx_din   (o_tx_din),
    .i_tx_done  (i_tx_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: idle/busy, pending byte queue, strobe and ack pulse.
  logic            m_busy = 1'b0;
  logic            m_strobe = 1'b0;
  logic [NREQ-1:0] m_ack = '0;
  int              m_gid = NREQ - 1;
  logic [7:0]      m_q[$];

  function automatic int rr_next(input int last, input logic [NREQ-1:0] e);
    for (int i = 1; i <= NREQ; i++)
      if (e[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  function automatic void exp_seq(input int id, input logic [NBYTES*8-1:0] w,
                                  ref logic [7:0] q[$]);
    q.delete();
`ifdef UART_TX_ARB_HEADER_EN
    q.push_back(8'hA0 + 8'(id));
`endif
    for (int j = 0; j < NBYTES; j++) q.push_back(w[j*8 +: 8]);
  endfunction

  task automatic m_step(input logic rst, input logic [NREQ-1:0] rq,
                        input logic dn, input logic [DW-1:0] dat);
    logic [NREQ-1:0] ackp;
    int w;
    ackp  = m_ack;
    m_ack = '0;
    if (rst) begin
      m_busy = 0; m_strobe = 0; m_gid = NREQ - 1; m_q.delete();
      return;
    end
    if (!m_busy) begin
      w = rr_next(m_gid, rq & ~ackp);
      if (w >= 0) begin
        m_gid = w;
        exp_seq(w, dat[w*NBYTES*8 +: NBYTES*8], m_q);
        m_busy = 1; m_strobe = 1;
      end
    end else if (m_strobe) begin
      m_strobe = 0;
    end else if (dn) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0;
        m_ack[m_gid] = 1'b1;
      end else begin
        m_strobe = 1;
      end
    end
  endtask

  int         cyc = 0;
  int         ack_cyc = 0;
  int         start_cyc = 0;
  int         cnt = 0;
  int         tx_dly = 20;
  bit         rnd_dly = 0;
  logic       busy_p = 0;
  int         glog[$];
  logic [7:0] blog[$];
  logic [3:0] alog[$];

  task automatic clr_logs();
    glog.delete(); blog.delete(); alog.delete();
  endtask

  task automatic tick();
    logic r, d;
    logic [NREQ-1:0] q;
    logic [DW-1:0] dt;
    r = i_reset; q = i_req; d = i_tx_done; dt = i_data;
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    m_step(r, q, d, dt);
    chk("busy", o_busy, m_busy);
    chk("tx_start", o_tx_start, m_strobe);
    chk("ack", o_ack, m_ack);
    chk("grant_id", o_grant_id, m_gid);
    if (m_strobe && m_q.size() > 0) chk("tx_din", o_tx_din, m_q[0]);
    if (o_busy && !busy_p) glog.push_back(int'(o_grant_id));
    busy_p = o_busy;
    if (o_tx_start) begin
      blog.push_back(o_tx_din);
      start_cyc = cyc;
    end
    if (o_ack != 0) begin
      alog.push_back(o_ack);
      ack_cyc = cyc;
    end
    i_tx_done = 1'b0;
    if (i_reset) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_tx_done = 1'b1;
      end
      if (o_tx_start) cnt = rnd_dly ? int'($urandom_range(1, 4)) : tx_dly;
    end
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    repeat (n) tick();
    i_reset = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_start"}, o_tx_start, 0);
    chk({tag, "_din"}, o_tx_din, 8'h00);
    chk({tag, "_ack"}, o_ack, 0);
    chk({tag, "_gid"}, o_grant_id, NREQ - 1);
  endtask

  task automatic wait_ack(input int id, input int budget, input bit drop);
    int n = 0;
    while (n < budget && !o_ack[id]) begin
      tick();
      n++;
    end
    if (!o_ack[id]) chk("ack_timeout", 0, 1);
    else if (drop) i_req[id] = 1'b0;
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] e[$]);
    chk({tag, "_nbytes"}, blog.size(), e.size());
    for (int i = 0; i < e.size() && i < blog.size(); i++)
      chk({tag, "_byte"}, blog[i], e[i]);
  endtask

  logic [7:0]          eq[$];
  logic [NBYTES*8-1:0] w;
  int                  n;

  initial begin
    i_reset = 1'b1; i_req = '0; i_tx_done = 1'b0;
    i_data = {$urandom, $urandom, $urandom, $urandom};

    // single request
    do_reset(2);
    chk_rst("rst");
    clr_logs();
    i_data[31:0] = 32'hDEADBEEF;
    i_req = 4'b0001;
    tx_dly = 20;
    wait_ack(0, 600, 1);
    repeat (3) tick();
`ifdef UART_TX_ARB_HEADER_EN
    eq = {8'hA0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`else
    eq = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
    chk_bytes("single", eq);
    chk("single_nack", alog.size(), 1);
    chk("single_ackv", alog.size() > 0 ? alog[0] : 4'h0, 4'b0001);
    chk("single_gid", o_grant_id, 0);

    // round robin with all requesting
    tx_dly = 3;
    do_reset(2);
    clr_logs();
    i_req = 4'b1111;
    n = 0;
    while (glog.size() < 5 && n < 2000) begin tick(); n++; end
    chk("rr_ngrants", glog.size() >= 5, 1);
    eq = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk("rr_order", glog[i], eq[i]);

    // data change after grant
    do_reset(2);
    clr_logs();
    i_req = 4'b0100;
    w = i_data[2*NBYTES*8 +: NBYTES*8];
    n = 0;
    while (!o_busy && n < 10) begin tick(); n++; end
    tick();
    i_data = ~i_data;
    wait_ack(2, 500, 1);
    exp_seq(2, w, eq);
    chk_bytes("stable", eq);

    // spurious done pulses in IDLE and START
    tx_dly = 5;
    do_reset(2);
    clr_logs();
    i_tx_done = 1'b1;
    tick(); tick();
    chk("sp_idle_nstart", blog.size(), 0);
    chk("sp_idle_nack", alog.size(), 0);
    w = i_data[NBYTES*8-1:0];
    i_req = 4'b0001;
    n = 0;
    while (!m_strobe && n < 10) begin tick(); n++; end
    i_tx_done = 1'b1;
    tick();
    wait_ack(0, 500, 1);
    repeat (3) tick();
    exp_seq(0, w, eq);
    chk_bytes("spur", eq);
    chk("sp_nack", alog.size(), 1);

    // reset mid-transfer
    tx_dly = 6;
    do_reset(2);
    clr_logs();
    i_req = 4'b0001;
    n = 0;
    while (blog.size() < 2 && n < 200) begin tick(); n++; end
    tick(); tick();
    i_reset = 1'b1;
    tick();
    chk_rst("rmid");
    i_req = 4'b0100;
    tick();
    i_reset = 1'b0;
    chk("rmid_noack", alog.size(), 0);
    clr_logs();
    w = i_data[2*NBYTES*8 +: NBYTES*8];
    wait_ack(2, 600, 1);
    exp_seq(2, w, eq);
    chk_bytes("rmid", eq);
    chk("rmid_nack", alog.size(), 1);
    chk("rmid_ackv", alog.size() > 0 ? alog[0] : 4'h0, 4'b0100);

    // ack-cycle exclusion
    tx_dly = 3;
    do_reset(2);
    clr_logs();
    i_req = 4'b1010;
    wait_ack(1, 500, 0);
    n = 0;
    while (glog.size() < 2 && n < 20) begin tick(); n++; end
    chk("ax_first", glog.size() > 0 ? glog[0] : -1, 1);
    chk("ax_next", glog.size() > 1 ? glog[1] : -1, 3);
    wait_ack(3, 500, 1);
    wait_ack(1, 500, 0);
    n = 0;
    while (!o_tx_start && n < 10) begin tick(); n++; end
    chk("ax_gap", start_cyc - ack_cyc, 2);
    chk("ax_regrant", o_grant_id, 1);

    // randomized traffic
    i_req = '0;
    rnd_dly = 1;
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int r = 0; r < NREQ; r++) begin
        if (o_ack[r] && $urandom_range(0, 1) == 1) i_req[r] = 1'b0;
        else if (!i_req[r] && $urandom_range(0, 5) == 0) i_req[r] = 1'b1;
        else if (i_req[r] && $urandom_range(0, 99) == 0) i_req[r] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0)
        i_data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 49) == 0) i_tx_done = 1'b1;
      i_reset = ($urandom_range(0, 599) == 0);
    end
    i_reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
